// File: rtl/sc_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module   : sc_fifo_ext
// Purpose  : Single-clock show-ahead FIFO. Storage is a synchronous-read RAM
//            plus one output register. A one-word look-ahead RAM read keeps
//            throughput at one word per cycle.
// Options  : SC_FIFO_ERR_FLAGS_EN - adds sticky overflow_o / underflow_o.
// Revision : 1.0 - initial release
// ============================================================================
module sc_fifo_ext #(
   parameter int DATA_WIDTH   = 8,
   parameter int WORDS_AMOUNT = 8,
   parameter int ADDR_WIDTH   = $clog2(WORDS_AMOUNT),
   parameter int AF_LEVEL     = WORDS_AMOUNT - 2,
   parameter int AE_LEVEL     = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  wr_i,
   input  logic                  rd_i,
   input  logic                  flush_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic [ADDR_WIDTH:0]   used_words_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o
`ifdef SC_FIFO_ERR_FLAGS_EN
   ,
   output logic                  overflow_o,
   output logic                  underflow_o
`endif
);

   localparam int                PTR_W     = ADDR_WIDTH + 1;
   localparam logic [PTR_W-1:0]  C_ONE     = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0]  C_WORDS   = PTR_W'(WORDS_AMOUNT);
   localparam logic [PTR_W-1:0]  C_AF_LVL  = PTR_W'(AF_LEVEL);
   localparam logic [PTR_W-1:0]  C_AE_LVL  = PTR_W'(AE_LEVEL);

   // Storage and pipeline state
   logic [DATA_WIDTH-1:0] mem_q [WORDS_AMOUNT];
   logic [DATA_WIDTH-1:0] ram_rd_q;
   logic [DATA_WIDTH-1:0] out_q, out_d;
   logic                  out_vld_q, out_vld_d;
   logic                  ram_vld_q, ram_vld_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      used_q, used_d;

   logic                  wr_acc;
   logic                  rd_acc;
   logic                  load;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] rd_addr;

   // Outputs decode registered state only
   assign rd_data_o      = out_q;
   assign used_words_o   = used_q;
   assign full_o         = (used_q == C_WORDS);
   assign empty_o        = ~out_vld_q;
   assign almost_full_o  = (used_q >= C_AF_LVL);
   assign almost_empty_o = (used_q <= C_AE_LVL);

   // Next-state: accept requests, refill the output register, track occupancy
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      used_d    = used_q;
      out_d     = out_q;
      out_vld_d = out_vld_q;

      wr_acc = wr_i & ~full_o;
      rd_acc = rd_i & out_vld_q;
      // ram_rd_q already holds the word at rd_ptr when ram_vld_q is set, so
      // the output register can refill in the same cycle it is consumed.
      load   = ram_vld_q & (~out_vld_q | rd_acc);

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + C_ONE;
      end

      if (load) begin
         rd_ptr_d  = rd_ptr_q + C_ONE;
         out_d     = ram_rd_q;
         out_vld_d = 1'b1;
      end else if (rd_acc) begin
         out_vld_d = 1'b0;
      end

      if (wr_acc && !rd_acc) begin
         used_d = used_q + C_ONE;
      end else if (!wr_acc && rd_acc) begin
         used_d = used_q - C_ONE;
      end

      // Look-ahead address: fetch the word that will be at the head of RAM
      // after this edge. The fetched word is usable only if it was written
      // before this edge (read-during-write returns old data).
      rd_addr   = rd_ptr_d[ADDR_WIDTH-1:0];
      ram_vld_d = (rd_ptr_d != wr_ptr_q);
      ram_we    = wr_acc & ~flush_i;

      if (flush_i) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         used_d    = '0;
         out_vld_d = 1'b0;
         ram_vld_d = 1'b0;
      end
   end

   // RAM: write port and registered look-ahead read port, no reset
   always_ff @(posedge clk_i) begin
      if (ram_we) begin
         mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data_i;
      end
      ram_rd_q <= mem_q[rd_addr];
   end

   // Control registers with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         used_q    <= '0;
         out_q     <= '0;
         out_vld_q <= 1'b0;
         ram_vld_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         used_q    <= used_d;
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
         ram_vld_q <= ram_vld_d;
      end
   end

`ifdef SC_FIFO_ERR_FLAGS_EN
   logic ovf_q;
   logic udf_q;

   assign overflow_o  = ovf_q;
   assign underflow_o = udf_q;

   // Sticky error flags: set on rejected requests, cleared by reset or flush
   always_ff @(posedge clk_i) begin
      if (!rst_i || flush_i) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (wr_i && full_o) begin
            ovf_q <= 1'b1;
         end
         if (rd_i && empty_o) begin
            udf_q <= 1'b1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sc_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_fifo_ext
// Purpose  : Self-checking bench for sc_fifo_ext (8 x 8, AF=6, AE=2).
//            Table of directed vectors plus a sustained-throughput sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_fifo_ext;

   localparam int NV = 45;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [7:0] wr_data_i;
   logic       wr_i;
   logic       rd_i;
   logic       flush_i;
   logic [7:0] rd_data_o;
   logic [3:0] used_words_o;
   logic       full_o;
   logic       empty_o;
   logic       almost_full_o;
   logic       almost_empty_o;
`ifdef SC_FIFO_ERR_FLAGS_EN
   logic       overflow_o;
   logic       underflow_o;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   sc_fifo_ext #(
      .DATA_WIDTH   (8),
      .WORDS_AMOUNT (8),
      .AF_LEVEL     (6),
      .AE_LEVEL     (2)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .wr_data_i      (wr_data_i),
      .wr_i           (wr_i),
      .rd_i           (rd_i),
      .flush_i        (flush_i),
      .rd_data_o      (rd_data_o),
      .used_words_o   (used_words_o),
      .full_o         (full_o),
      .empty_o        (empty_o),
      .almost_full_o  (almost_full_o),
      .almost_empty_o (almost_empty_o)
`ifdef SC_FIFO_ERR_FLAGS_EN
      ,
      .overflow_o     (overflow_o),
      .underflow_o    (underflow_o)
`endif
   );

   typedef struct {
      logic       rst_n;
      logic       flush;
      logic       wr;
      logic       rd;
      logic [7:0] wdata;
      int         e_used;
      logic       e_empty;
      logic [7:0] e_data;
      logic       e_ovf;
      logic       e_udf;
   } vec_t;

   vec_t vecs [NV];

   function automatic vec_t mk(input logic rn, input logic fl, input logic wr,
                               input logic rd, input logic [7:0] wd, input int used,
                               input logic emp, input logic [7:0] dat,
                               input logic ovf, input logic udf);
      vec_t v;
      v.rst_n = rn; v.flush = fl; v.wr = wr; v.rd = rd; v.wdata = wd;
      v.e_used = used; v.e_empty = emp; v.e_data = dat; v.e_ovf = ovf; v.e_udf = udf;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic rn, input logic fl, input logic wr, input logic rd,
                        input logic [7:0] wd);
      rst_i = rn; flush_i = fl; wr_i = wr; rd_i = rd; wr_data_i = wd;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      //                rstn fl wr rd wdata  used empty data  ovf udf
      vecs[0]  = mk(1'b0,1'b0,1'b0,1'b0,8'h00, 0,1'b1,8'h00,1'b0,1'b0); // reset
      vecs[1]  = mk(1'b1,1'b0,1'b1,1'b0,8'h11, 1,1'b1,8'h00,1'b0,1'b0);
      vecs[2]  = mk(1'b1,1'b0,1'b0,1'b0,8'h00, 1,1'b1,8'h00,1'b0,1'b0);
      vecs[3]  = mk(1'b1,1'b0,1'b0,1'b0,8'h00, 1,1'b0,8'h11,1'b0,1'b0); // first word visible
      vecs[4]  = mk(1'b1,1'b0,1'b0,1'b1,8'h00, 0,1'b1,8'h00,1'b0,1'b0);
      vecs[5]  = mk(1'b1,1'b0,1'b0,1'b1,8'h00, 0,1'b1,8'h00,1'b0,1'b1); // underflow
      vecs[6]  = mk(1'b0,1'b0,1'b0,1'b0,8'h00, 0,1'b1,8'h00,1'b0,1'b0); // reset clears flag
      vecs[7]  = mk(1'b1,1'b0,1'b1,1'b0,8'h00, 1,1'b1,8'h00,1'b0,1'b0);
      vecs[8]  = mk(1'b1,1'b0,1'b1,1'b0,8'h01, 2,1'b1,8'h00,1'b0,1'b0);
      vecs[9]  = mk(1'b1,1'b0,1'b1,1'b0,8'h02, 3,1'b0,8'h00,1'b0,1'b0);
      vecs[10] = mk(1'b1,1'b0,1'b1,1'b0,8'h03, 4,1'b0,8'h00,1'b0,1'b0);
      vecs[11] = mk(1'b1,1'b0,1'b1,1'b0,8'h04, 5,1'b0,8'h00,1'b0,1'b0);
      vecs[12] = mk(1'b1,1'b0,1'b1,1'b0,8'h05, 6,1'b0,8'h00,1'b0,1'b0);
      vecs[13] = mk(1'b1,1'b0,1'b1,1'b0,8'h06, 7,1'b0,8'h00,1'b0,1'b0);
      vecs[14] = mk(1'b1,1'b0,1'b1,1'b0,8'h07, 8,1'b0,8'h00,1'b0,1'b0); // full
      vecs[15] = mk(1'b1,1'b0,1'b1,1'b0,8'hAA, 8,1'b0,8'h00,1'b1,1'b0); // overflow
      vecs[16] = mk(1'b1,1'b0,1'b1,1'b1,8'hBB, 7,1'b0,8'h01,1'b1,1'b0); // wr+rd while full
      vecs[17] = mk(1'b1,1'b0,1'b0,1'b1,8'h00, 6,1'b0,8'h02,1'b1,1'b0);
      vecs[18] = mk(1'b1,1'b0,1'b0,1'b1,8'h00, 5,1'b0,8'h03,1'b1,1'b0);
      vecs[19] = mk(1'b1,1'b0,1'b0,1'b1,8'h00, 4,1'b0,8'h04,1'b1,1'b0);
      vecs[20] = mk(1'b1,1'b0,1'b0,1'b1,8'h00, 3,1'b0,8'h05,1'b1,1'b0);
      vecs[21] = mk(1'b1,1'b0,1'b0,1'b1,8'h00, 2,1'b0,8'h06,1'b1,1'b0);
      vecs[22] = mk(1'b1,1'b0,1'b0,1'b1,8'h00, 1,1'b0,8'h07,1'b1,1'b0);
      vecs[23] = mk(1'b1,1'b0,1'b0,1'b1,8'h00, 0,1'b1,8'h00,1'b1,1'b0);
      vecs[24] = mk(1'b1,1'b0,1'b0,1'b0,8'h00, 0,1'b1,8'h00,1'b1,1'b0); // 0xBB never stored
      vecs[25] = mk(1'b1,1'b0,1'b1,1'b0,8'h20, 1,1'b1,8'h00,1'b1,1'b0);
      vecs[26] = mk(1'b1,1'b0,1'b1,1'b0,8'h21, 2,1'b1,8'h00,1'b1,1'b0);
      vecs[27] = mk(1'b1,1'b0,1'b1,1'b0,8'h22, 3,1'b0,8'h20,1'b1,1'b0);
      vecs[28] = mk(1'b1,1'b0,1'b1,1'b0,8'h23, 4,1'b0,8'h20,1'b1,1'b0);
      vecs[29] = mk(1'b1,1'b0,1'b1,1'b0,8'h24, 5,1'b0,8'h20,1'b1,1'b0);
      vecs[30] = mk(1'b1,1'b1,1'b1,1'b0,8'h99, 0,1'b1,8'h00,1'b0,1'b0); // flush beats write
      vecs[31] = mk(1'b1,1'b0,1'b0,1'b1,8'h00, 0,1'b1,8'h00,1'b0,1'b1);
      vecs[32] = mk(1'b1,1'b0,1'b0,1'b0,8'h00, 0,1'b1,8'h00,1'b0,1'b1);
      vecs[33] = mk(1'b1,1'b0,1'b0,1'b0,8'h00, 0,1'b1,8'h00,1'b0,1'b1);
      vecs[34] = mk(1'b1,1'b0,1'b1,1'b0,8'h31, 1,1'b1,8'h00,1'b0,1'b1);
      vecs[35] = mk(1'b1,1'b0,1'b1,1'b0,8'h32, 2,1'b1,8'h00,1'b0,1'b1);
      vecs[36] = mk(1'b1,1'b0,1'b1,1'b0,8'h33, 3,1'b0,8'h31,1'b0,1'b1);
      vecs[37] = mk(1'b0,1'b0,1'b1,1'b0,8'h77, 0,1'b1,8'h00,1'b0,1'b0); // reset beats write
      vecs[38] = mk(1'b1,1'b0,1'b1,1'b0,8'h5A, 1,1'b1,8'h00,1'b0,1'b0);
      vecs[39] = mk(1'b1,1'b0,1'b0,1'b0,8'h00, 1,1'b1,8'h00,1'b0,1'b0);
      vecs[40] = mk(1'b1,1'b0,1'b0,1'b0,8'h00, 1,1'b0,8'h5A,1'b0,1'b0);
      vecs[41] = mk(1'b1,1'b0,1'b0,1'b1,8'h00, 0,1'b1,8'h00,1'b0,1'b0);
      vecs[42] = mk(1'b1,1'b0,1'b1,1'b1,8'h66, 1,1'b1,8'h00,1'b0,1'b1); // wr+rd while empty
      vecs[43] = mk(1'b1,1'b0,1'b0,1'b0,8'h00, 1,1'b1,8'h00,1'b0,1'b1);
      vecs[44] = mk(1'b1,1'b0,1'b0,1'b0,8'h00, 1,1'b0,8'h66,1'b0,1'b1);

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].rst_n, vecs[i].flush, vecs[i].wr, vecs[i].rd, vecs[i].wdata);
         tick();
         check("used", i, int'(used_words_o), vecs[i].e_used);
         check("empty", i, int'(empty_o), int'(vecs[i].e_empty));
         check("full", i, int'(full_o), int'(vecs[i].e_used == 8));
         check("afull", i, int'(almost_full_o), int'(vecs[i].e_used >= 6));
         check("aempty", i, int'(almost_empty_o), int'(vecs[i].e_used <= 2));
         if (!vecs[i].e_empty || !vecs[i].rst_n)
            check("data", i, int'(rd_data_o), int'(vecs[i].e_data));
`ifdef SC_FIFO_ERR_FLAGS_EN
         check("ovf", i, int'(overflow_o), int'(vecs[i].e_ovf));
         check("udf", i, int'(underflow_o), int'(vecs[i].e_udf));
`endif
      end

      // Sustained write+read across pointer wrap: preload three words
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h40 + 8'(i));
         tick();
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      tick();
      check("pre_data", 100, int'(rd_data_o), 'h40);
      check("pre_used", 100, int'(used_words_o), 3);
      for (int i = 0; i < 20; i++) begin
         check("sus_data", 200 + i, int'(rd_data_o), 'h40 + i);
         drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h43 + 8'(i));
         tick();
         check("sus_used", 200 + i, int'(used_words_o), 3);
         check("sus_empty", 200 + i, int'(empty_o), 0);
      end
      // Drain back-to-back: each read exposes the next word on the next edge
      for (int i = 0; i < 3; i++) begin
         check("drain_data", 300 + i, int'(rd_data_o), 'h54 + i);
         drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
         tick();
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      check("drain_empty", 303, int'(empty_o), 1);
      check("drain_used", 303, int'(used_words_o), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
